// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the pipelined RISC-V core.
// Owns the fetch PC, drives the instruction-memory request handshake, applies
// decode stalls and execute redirects, and holds the IF/ID output register.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY   = 2,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_d,
    input  logic        redirect_e,
    input  logic [31:0] redirect_target_e,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic        valid_d,
    output logic [31:0] fetch_pc,
    output logic        fetch_fault,
    output logic [15:0] bubble_cnt
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned BUB_W = 16;

    localparam logic [CNT_W-1:0] BOOT_INIT = CNT_W'(BOOT_DELAY);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(4);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // A zero boot delay skips the idle window and fetches straight out of reset.
    localparam state_t ST_RESET = (BOOT_DELAY == 0) ? ST_RUN : ST_BOOT;

    state_t           r_state;
    logic [CNT_W-1:0] r_boot_cnt;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_instr;
    logic [XLEN-1:0]  r_pc;
    logic             r_valid;
    logic             r_fault;
    logic [BUB_W-1:0] r_bubble_cnt;

    logic             w_misaligned;
    logic [XLEN-1:0]  w_pc_next;
    logic             w_bubble_sat;

    // Redirect alignment check, sequential PC increment (wraps modulo 2^32), counter saturation.
    assign w_misaligned = (redirect_target_e[1:0] != 2'b00);
    assign w_pc_next    = r_fetch_pc + PC_STEP;
    assign w_bubble_sat = &r_bubble_cnt;

    // Request is only issued while running and decode is not holding the pipe.
    assign imem_req  = (r_state == ST_RUN) && !stall_d;
    assign imem_addr = r_fetch_pc;

    assign instr_d     = r_instr;
    assign pc_d        = r_pc;
    assign valid_d     = r_valid;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_fault = r_fault;
    assign bubble_cnt  = r_bubble_cnt;

    // Fetch sequencer: boot countdown, run-time priority (redirect > stall > data > wait), fault lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RESET;
            r_boot_cnt   <= BOOT_INIT;
            r_fetch_pc   <= RESET_VECTOR;
            r_instr      <= NOP_INSTR;
            r_pc         <= '0;
            r_valid      <= 1'b0;
            r_fault      <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_boot_cnt <= r_boot_cnt - CNT_W'(1);
                    if (r_boot_cnt == CNT_W'(1)) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (redirect_e) begin
                        // Any returned word is stale once a redirect lands.
                        r_fetch_pc <= redirect_target_e;
                        r_valid    <= 1'b0;
                        r_instr    <= NOP_INSTR;
                        if (w_misaligned) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                        end
                    end else if (stall_d) begin
                        // Hold IF/ID and PC so no instruction is lost or duplicated.
                        r_fetch_pc <= r_fetch_pc;
                    end else if (imem_ready) begin
                        r_instr    <= imem_rdata;
                        r_pc       <= r_fetch_pc;
                        r_valid    <= 1'b1;
                        r_fetch_pc <= w_pc_next;
                    end else begin
                        // Memory wait: insert a bubble and keep the address on the bus.
                        r_valid <= 1'b0;
                        r_instr <= NOP_INSTR;
                        if (!w_bubble_sat) begin
                            r_bubble_cnt <= r_bubble_cnt + BUB_W'(1);
                        end
                    end
                end

                ST_FAULT: begin
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end

                default: begin
                    // Unreachable encoding: park in the fault state until reset.
                    r_state <= ST_FAULT;
                    r_valid <= 1'b0;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed bench for fetch_ctrl with a cycle model and an IF/ID scoreboard.
module tb_fetch_ctrl;

    localparam logic [31:0] RV  = 32'h0000_0100;
    localparam int unsigned BD  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        rst_n;
    logic        stall_d;
    logic        redirect_e;
    logic [31:0] redirect_target_e;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic [31:0] fetch_pc;
    logic        fetch_fault;
    logic [15:0] bubble_cnt;

    // Wrap-around DUT signals
    logic        w_rst_n;
    logic        w_stall_d;
    logic        w_redirect_e;
    logic [31:0] w_redirect_target_e;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_ready;
    logic [31:0] w_imem_rdata;
    logic [31:0] w_instr_d;
    logic [31:0] w_pc_d;
    logic        w_valid_d;
    logic [31:0] w_fetch_pc;
    logic        w_fetch_fault;
    logic [15:0] w_bubble_cnt;

    // Instruction memory contents: one marker word, the rest derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0108) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0013;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign w_imem_rdata = mem_word(w_imem_addr);

    fetch_ctrl #(.RESET_VECTOR(RV), .BOOT_DELAY(BD), .NOP_INSTR(NOP)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_d           (stall_d),
        .redirect_e        (redirect_e),
        .redirect_target_e (redirect_target_e),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata),
        .instr_d           (instr_d),
        .pc_d              (pc_d),
        .valid_d           (valid_d),
        .fetch_pc          (fetch_pc),
        .fetch_fault       (fetch_fault),
        .bubble_cnt        (bubble_cnt)
    );

    fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFF8), .BOOT_DELAY(0), .NOP_INSTR(NOP)) u_wrap (
        .clk               (clk),
        .rst_n             (w_rst_n),
        .stall_d           (w_stall_d),
        .redirect_e        (w_redirect_e),
        .redirect_target_e (w_redirect_target_e),
        .imem_req          (w_imem_req),
        .imem_addr         (w_imem_addr),
        .imem_ready        (w_imem_ready),
        .imem_rdata        (w_imem_rdata),
        .instr_d           (w_instr_d),
        .pc_d              (w_pc_d),
        .valid_d           (w_valid_d),
        .fetch_pc          (w_fetch_pc),
        .fetch_fault       (w_fetch_fault),
        .bubble_cnt        (w_bubble_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model state
    typedef enum int {M_BOOT, M_RUN, M_FAULT} mstate_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ifid_t;

    mstate_t     m_state = M_BOOT;
    int          m_cnt   = 0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pcd   = '0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [15:0] m_bub   = '0;
    bit          m_known = 1'b0;
    bit          m_pend  = 1'b0;
    ifid_t       sb_q[$];

    // One clock: drive inputs, compare outputs against the model, advance model and DUT.
    task automatic cyc(input logic rstn, input logic st, input logic rd,
                       input logic [31:0] tg, input logic rdy);
        ifid_t e;
        rst_n             = rstn;
        stall_d           = st;
        redirect_e        = rd;
        redirect_target_e = tg;
        imem_ready        = rdy;
        if (m_pend && sb_q.size() > 0) begin
            e       = sb_q.pop_front();
            m_instr = e.instr;
            m_pcd   = e.pc;
            m_pend  = 1'b0;
        end
        #1;
        if (m_known) begin
            chk("m_req",      32'(imem_req),    32'((m_state == M_RUN) && !st));
            chk("m_addr",     imem_addr,        m_pc);
            chk("m_fetch_pc", fetch_pc,         m_pc);
            chk("m_valid",    32'(valid_d),     32'(m_valid));
            chk("m_fault",    32'(fetch_fault), 32'(m_fault));
            chk("m_bubble",   32'(bubble_cnt),  32'(m_bub));
            chk("m_instr",    instr_d,          m_instr);
            chk("m_pc_d",     pc_d,             m_pcd);
        end
        if (!rstn) begin
            m_state = (BD == 0) ? M_RUN : M_BOOT;
            m_cnt   = BD;
            m_pc    = RV;
            m_valid = 1'b0;
            m_instr = NOP;
            m_pcd   = '0;
            m_fault = 1'b0;
            m_bub   = '0;
            m_pend  = 1'b0;
            m_known = 1'b1;
            sb_q.delete();
        end else begin
            case (m_state)
                M_BOOT: begin
                    if (m_cnt == 1) m_state = M_RUN;
                    m_cnt--;
                end
                M_RUN: begin
                    if (rd) begin
                        m_pc    = tg;
                        m_valid = 1'b0;
                        m_instr = NOP;
                        if (tg[1:0] != 2'b00) begin
                            m_state = M_FAULT;
                            m_fault = 1'b1;
                        end
                    end else if (st) begin
                        m_pc = m_pc;
                    end else if (rdy) begin
                        sb_q.push_back('{instr: mem_word(m_pc), pc: m_pc});
                        m_pend  = 1'b1;
                        m_pc    = m_pc + 32'd4;
                        m_valid = 1'b1;
                    end else begin
                        m_valid = 1'b0;
                        m_instr = NOP;
                        if (m_bub != 16'hFFFF) m_bub++;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        w_rst_n             = 1'b0;
        w_stall_d           = 1'b0;
        w_redirect_e        = 1'b0;
        w_redirect_target_e = '0;
        w_imem_ready        = 1'b1;

        // Reset
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_valid",  32'(valid_d),     32'd0);
        chk("rst_instr",  instr_d,          NOP);
        chk("rst_pc_d",   pc_d,             32'h0);
        chk("rst_addr",   imem_addr,        32'h100);
        chk("rst_bubble", 32'(bubble_cnt),  32'd0);
        chk("rst_fault",  32'(fetch_fault), 32'd0);
        w_rst_n = 1'b1;

        // Boot window: request low in cycles 0-1, high in cycle 2
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("boot_c1_req", 32'(imem_req), 32'd0);
        chk("wrap_c0_pc",  w_fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_c0_pcd", w_pc_d,     32'hFFFF_FFF8);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("boot_c2_req",  32'(imem_req), 32'd1);
        chk("boot_c2_addr", imem_addr,     32'h100);
        chk("wrap_c1_pc",   w_fetch_pc,    32'h0000_0000);
        chk("wrap_c1_pcd",  w_pc_d,        32'hFFFF_FFFC);
        chk("wrap_c1_vld",  32'(w_valid_d), 32'd1);

        // First fetch, zero-wait memory
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("c3_valid", 32'(valid_d), 32'd1);
        chk("c3_pc_d",  pc_d,         32'h100);
        chk("c3_instr", instr_d,      mem_word(32'h100));
        chk("c3_addr",  imem_addr,    32'h104);

        // Three memory-wait cycles at 0x104
        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("wait_valid", 32'(valid_d), 32'd0);
            chk("wait_addr",  imem_addr,    32'h104);
        end
        chk("wait_bubble", 32'(bubble_cnt), 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wait_done_pcd",   pc_d,    32'h104);
        chk("wait_done_instr", instr_d, mem_word(32'h104));

        // Fetch the marker word, then stall two cycles
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("mark_instr", instr_d, 32'hDEAD_BEEF);
        repeat (2) begin
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
            chk("stall_req",   32'(imem_req), 32'd0);
            chk("stall_instr", instr_d,       32'hDEAD_BEEF);
            chk("stall_pcd",   pc_d,          32'h108);
            chk("stall_fpc",   fetch_pc,      32'h10C);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("resume_pcd", pc_d, 32'h10C);

        // Redirect colliding with stall and ready
        cyc(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
        chk("coll_addr",  imem_addr,    32'h200);
        chk("coll_valid", 32'(valid_d), 32'd0);
        chk("coll_instr", instr_d,      NOP);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("tgt_pcd",   pc_d,    32'h200);
        chk("tgt_instr", instr_d, mem_word(32'h200));

        // Redirect to the top of memory, then redirect away from it
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b1, 32'h300, 1'b1);
        chk("top_redir_addr",  imem_addr,    32'h300);
        chk("top_redir_valid", 32'(valid_d), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("pre_rst_valid", 32'(valid_d), 32'd1);

        // Reset mid-stream with memory waiting
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("mid_rst_valid",  32'(valid_d),    32'd0);
        chk("mid_rst_instr",  instr_d,         NOP);
        chk("mid_rst_pcd",    pc_d,            32'h0);
        chk("mid_rst_bubble", 32'(bubble_cnt), 32'd0);
        chk("mid_rst_addr",   imem_addr,       32'h100);
        chk("mid_rst_req",    32'(imem_req),   32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("reboot_c1_req", 32'(imem_req), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("reboot_c2_req", 32'(imem_req), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("reboot_pcd", pc_d, 32'h100);

        // Misaligned redirect locks fetch until reset
        cyc(1'b1, 1'b0, 1'b1, 32'h202, 1'b1);
        chk("flt_fault", 32'(fetch_fault), 32'd1);
        chk("flt_req",   32'(imem_req),    32'd0);
        chk("flt_addr",  imem_addr,        32'h202);
        chk("flt_valid", 32'(valid_d),     32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'($urandom), 1'($urandom), {$urandom} & 32'hFFFF_FFFC, 1'($urandom));
            chk("flt_hold_fault", 32'(fetch_fault), 32'd1);
            chk("flt_hold_addr",  imem_addr,        32'h202);
            chk("flt_hold_req",   32'(imem_req),    32'd0);
            chk("flt_hold_valid", 32'(valid_d),     32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("flt_rst_fault", 32'(fetch_fault), 32'd0);
        chk("flt_rst_addr",  imem_addr,        32'h100);
        chk("flt_rst_req",   32'(imem_req),    32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("flt_boot_c1_req", 32'(imem_req), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("flt_boot_c2_req", 32'(imem_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the pipelined RISC-V core. It owns the fetch address (the PC), drives the instruction-memory request handshake, and applies decode stalls and execute-stage redirects. It also holds the IF/ID output register: fetched instruction, its PC and a valid bit. It sits between the hazard unit and execute redirect logic on one side and instruction memory and the decode stage on the other.

## Interface
- RESET_VECTOR, 32'h0000_0000, fetch address after reset
- BOOT_DELAY, 2, idle cycles after reset before the first fetch request (0–15)
- NOP_INSTR, 32'h0000_0013, value of instr_d when no valid instruction is held
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- stall_d  in  1  hazard-unit stall: hold the IF/ID register and the PC
- redirect_e  in  1  taken branch or jump resolved in execute
- redirect_target_e  in  32  new fetch address; valid when redirect_e=1
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; equals fetch_pc
- imem_ready  in  1  imem_rdata is valid this cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- valid_d  out  1  IF/ID holds a real instruction
- fetch_pc  out  32  current fetch address
- fetch_fault  out  1  misaligned redirect seen; fetch halted
- bubble_cnt  out  16  saturating count of memory-wait bubbles

## Operation
- States: BOOT, RUN, FAULT.
- Reset (rst_n=0 at an edge):
  - fetch_pc=RESET_VECTOR, valid_d=0, instr_d=NOP_INSTR, pc_d=0.
  - fetch_fault=0, bubble_cnt=0, boot counter=BOOT_DELAY.
  - State is BOOT, or RUN when BOOT_DELAY=0.
- Reset overrides everything, including a redirect, FAULT, or a pending memory wait.
- BOOT:
  - imem_req=0.
  - Counter decrements each cycle; state moves to RUN on the edge where the counter is 1.
  - redirect_e and stall_d are ignored.
- RUN: imem_req = !stall_d. Each edge applies exactly one case, in this priority order:
  1. redirect_e=1 and redirect_target_e[1:0]≠0: fetch_pc←target, valid_d←0, instr_d←NOP_INSTR, state←FAULT.
  2. redirect_e=1, aligned target: fetch_pc←target, valid_d←0, instr_d←NOP_INSTR. Applies even when stall_d=1 or imem_ready=1; imem_rdata is discarded.
  3. stall_d=1: all registers hold.
  4. imem_ready=1: instr_d←imem_rdata, pc_d←fetch_pc, valid_d←1, fetch_pc←fetch_pc+4.
  5. Otherwise (memory wait): valid_d←0, instr_d←NOP_INSTR, fetch_pc holds, bubble_cnt←bubble_cnt+1 saturating at 16'hFFFF.
- FAULT:
  - imem_req=0, valid_d=0, fetch_fault=1.
  - fetch_pc holds the faulting target.
  - Exit only through reset.
- Arithmetic:
  - fetch_pc+4 is a modulo-2^32 add: 32'hFFFF_FFFC wraps to 0.
  - fetch_pc[1:0] is always 0 outside FAULT.
- imem_addr is combinational from fetch_pc. imem_req is combinational from state and stall_d.

## Timing
- Cycle 0 is the first edge with rst_n=1. imem_req first rises in cycle BOOT_DELAY.
- Zero-wait memory (imem_ready=1 in the same cycle as imem_req): one instruction per cycle. valid_d rises one cycle after the request.
- Redirect latency:
  - Target appears on imem_addr the cycle after redirect_e.
  - valid_d is 0 in that cycle.
  - The first target instruction is valid in the cycle after that.
- Stall: outputs and fetch_pc hold for exactly the stalled cycles. No instruction is lost or duplicated.
- fetch_fault rises the cycle after the misaligned redirect.

## Test plan
- Reset with BOOT_DELAY=2, RESET_VECTOR=0x100, imem_ready=1 → imem_req low in cycles 0–1, high in cycle 2 with addr 0x100. Cycle 3: valid_d=1, pc_d=0x100, next addr 0x104.
- Memory waits: imem_ready low for 3 cycles at addr 0x104 → valid_d=0 for 3 cycles, addr stays 0x104, bubble_cnt=3. Then 0x104's instruction is delivered exactly once.
- stall_d high 2 cycles with instr 0xDEADBEEF in IF/ID → instr_d/pc_d/fetch_pc unchanged and imem_req=0 for 2 cycles. Fetch resumes at the held address.
- Collisions:
  - redirect_e with target 0x200 while stall_d=1 and imem_ready=1 → next cycle addr=0x200, valid_d=0. The returned word never appears on instr_d.
  - Redirect while fetch_pc=0xFFFF_FFFC → target taken.
  - Separate run with no redirect → 0xFFFF_FFFC wraps to 0x0.
- Misaligned redirect to 0x202 → fetch_fault=1, imem_req=0, fetch_pc=0x202 held through 10 cycles of any stimulus. rst_n=0 clears it back to BOOT.
- Reset mid-stream (rst_n low one cycle while valid_d=1 and memory waiting) → next cycle all outputs at reset values, bubble_cnt=0, boot sequence restarts.
